// File: rtl/eth_pkg.sv
// Shared Ethernet TX definitions: framer state encoding, MII nibble constants
// and the reflected CRC-32 nibble step.
package eth_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREAMBLE,
        S_SFD,
        S_DATA,
        S_PAD,
        S_FCS,
        S_ABORT,
        S_IFG
    } state_t;

    localparam logic [3:0]  PREAMBLE_NIB = 4'h5;
    localparam logic [3:0]  SFD_NIB      = 4'hD;
    localparam logic [31:0] CRC_POLY     = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT     = 32'hFFFFFFFF;

    // Four LSB-first bit steps of the reflected CRC-32.
    function automatic logic [31:0] crc32_nib(input logic [31:0] crc, input logic [3:0] nib);
        logic [31:0] c;
        c = crc ^ {28'd0, nib};
        for (int i = 0; i < 4; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/crc32_nib_gen.sv
// CRC-32 register advanced one MII nibble per enabled cycle; init wins over en.
module crc32_nib_gen
    import eth_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        init,
    input  logic        en,
    input  logic [3:0]  nib,
    output logic [31:0] crc
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            crc <= CRC_INIT;
        end else if (init) begin
            crc <= CRC_INIT;
        end else if (en) begin
            crc <= crc32_nib(crc, nib);
        end
    end

endmodule

// File: rtl/mii_tx_framer.sv
// Byte stream to MII nibble framer: preamble/SFD, body, zero pad, FCS, IFG.
// All MII outputs are registered together with the state they belong to.
module mii_tx_framer
    import eth_pkg::*;
#(
    parameter int PREAMBLE_BYTES  = 7,
    parameter int MIN_FRAME_BYTES = 60,
    parameter int IFG_BYTES       = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    input  logic        s_last,
    output logic        s_ready,
    output logic        txen,
    output logic        txer,
    output logic [3:0]  dataout,
    output logic        busy,
    output logic        underrun,
    output logic [15:0] frame_cnt,
    output logic [2:0]  state_dbg
);

    // Handshake: a byte transfers on a rising edge where s_valid && s_ready are
    // both high; s_ready is a registered one-cycle offer, and an offer met with
    // s_valid low aborts the frame.
    localparam logic [7:0]  PRE_LAST = 8'(2 * PREAMBLE_BYTES - 1);
    localparam logic [7:0]  IFG_LAST = 8'(2 * IFG_BYTES - 1);
    localparam logic [15:0] MIN_BC   = 16'(MIN_FRAME_BYTES);

    state_t      state, state_n;
    logic        ph, ph_n;
    logic [7:0]  cnt, cnt_n;
    logic [15:0] bc, bc_n, bc_inc;
    logic [7:0]  byte_q, byte_n;
    logic        last_q, last_n;
    logic        txen_n, txer_n, rdy_n, und_n, fc_inc;
    logic [3:0]  dout_n;
    logic        crc_init, crc_en;
    logic [31:0] crc, fcs_word;

    crc32_nib_gen u_crc (
        .clk   (clk),
        .reset (reset),
        .init  (crc_init),
        .en    (crc_en),
        .nib   (dout_n),
        .crc   (crc)
    );

    assign fcs_word  = ~crc;
    assign bc_inc    = (bc == 16'hFFFF) ? bc : bc + 16'd1;
    // The CRC follows the nibble being registered, so it is complete when FCS starts.
    assign crc_en    = (state_n == S_DATA) || (state_n == S_PAD);
    assign busy      = (state != S_IDLE);
    assign state_dbg = state;

    always_comb begin
        state_n  = state;
        ph_n     = ph;
        cnt_n    = cnt;
        bc_n     = bc;
        byte_n   = byte_q;
        last_n   = last_q;
        txen_n   = 1'b0;
        txer_n   = 1'b0;
        dout_n   = 4'h0;
        rdy_n    = 1'b0;
        und_n    = 1'b0;
        fc_inc   = 1'b0;
        crc_init = 1'b0;
        case (state)
            S_IDLE: begin
                if (s_valid) begin
                    state_n = S_PREAMBLE;
                    cnt_n   = 8'd0;
                    txen_n  = 1'b1;
                    dout_n  = PREAMBLE_NIB;
                end
            end
            S_PREAMBLE: begin
                txen_n = 1'b1;
                dout_n = PREAMBLE_NIB;
                if (cnt == PRE_LAST) begin
                    state_n = S_SFD;
                    ph_n    = 1'b0;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            S_SFD: begin
                txen_n = 1'b1;
                if (!ph) begin
                    ph_n     = 1'b1;
                    dout_n   = SFD_NIB;
                    rdy_n    = 1'b1;
                    bc_n     = 16'd0;
                    crc_init = 1'b1;
                end else if (s_valid) begin
                    state_n = S_DATA;
                    ph_n    = 1'b0;
                    byte_n  = s_data;
                    last_n  = s_last;
                    dout_n  = s_data[3:0];
                end else begin
                    state_n = S_ABORT;
                    txer_n  = 1'b1;
                    und_n   = 1'b1;
                end
            end
            S_DATA: begin
                txen_n = 1'b1;
                if (!ph) begin
                    ph_n   = 1'b1;
                    dout_n = byte_q[7:4];
                    rdy_n  = !last_q;
                end else begin
                    ph_n = 1'b0;
                    bc_n = bc_inc;
                    if (last_q) begin
                        if (bc_inc < MIN_BC) begin
                            state_n = S_PAD;
                        end else begin
                            state_n = S_FCS;
                            cnt_n   = 8'd0;
                            dout_n  = fcs_word[3:0];
                        end
                    end else if (s_valid) begin
                        byte_n = s_data;
                        last_n = s_last;
                        dout_n = s_data[3:0];
                    end else begin
                        state_n = S_ABORT;
                        txer_n  = 1'b1;
                        und_n   = 1'b1;
                    end
                end
            end
            S_PAD: begin
                txen_n = 1'b1;
                if (!ph) begin
                    ph_n = 1'b1;
                end else begin
                    ph_n = 1'b0;
                    bc_n = bc_inc;
                    if (bc_inc >= MIN_BC) begin
                        state_n = S_FCS;
                        cnt_n   = 8'd0;
                        dout_n  = fcs_word[3:0];
                    end
                end
            end
            S_FCS: begin
                if (cnt == 8'd7) begin
                    state_n = S_IFG;
                    cnt_n   = 8'd0;
                end else begin
                    txen_n = 1'b1;
                    cnt_n  = cnt + 8'd1;
                    dout_n = fcs_word[{cnt_n[2:0], 2'b00} +: 4];
                    fc_inc = (cnt == 8'd6);
                end
            end
            S_ABORT: begin
                state_n = S_IFG;
                cnt_n   = 8'd0;
            end
            S_IFG: begin
                if (cnt == IFG_LAST) begin
                    state_n = S_IDLE;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            ph        <= 1'b0;
            cnt       <= 8'd0;
            bc        <= 16'd0;
            byte_q    <= 8'd0;
            last_q    <= 1'b0;
            txen      <= 1'b0;
            txer      <= 1'b0;
            dataout   <= 4'h0;
            s_ready   <= 1'b0;
            underrun  <= 1'b0;
            frame_cnt <= 16'd0;
        end else begin
            state    <= state_n;
            ph       <= ph_n;
            cnt      <= cnt_n;
            bc       <= bc_n;
            byte_q   <= byte_n;
            last_q   <= last_n;
            txen     <= txen_n;
            txer     <= txer_n;
            dataout  <= dout_n;
            s_ready  <= rdy_n;
            underrun <= und_n;
            if (fc_inc) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_mii_tx_framer.sv
// Bench for mii_tx_framer: vector table, random frames against a byte-level
// frame model, and hand sequences for back-to-back, underrun and reset.
module tb_mii_tx_framer;
    import eth_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  s_data = 8'd0;
    logic        s_valid = 1'b0;
    logic        s_last = 1'b0;
    logic        s_ready, txen, txer, busy, underrun;
    logic [3:0]  dataout;
    logic [15:0] frame_cnt;
    logic [2:0]  state_dbg;

    logic        cu_init = 1'b0;
    logic        cu_en = 1'b0;
    logic [3:0]  cu_nib = 4'h0;
    logic [31:0] cu_crc;

    always #20 clk = ~clk;

    mii_tx_framer dut (
        .clk       (clk),
        .reset     (reset),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_last    (s_last),
        .s_ready   (s_ready),
        .txen      (txen),
        .txer      (txer),
        .dataout   (dataout),
        .busy      (busy),
        .underrun  (underrun),
        .frame_cnt (frame_cnt),
        .state_dbg (state_dbg)
    );

    crc32_nib_gen u_crc_unit (
        .clk   (clk),
        .reset (reset),
        .init  (cu_init),
        .en    (cu_en),
        .nib   (cu_nib),
        .crc   (cu_crc)
    );

    int n_pass = 0;
    int n_checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // ---------------- driver: presents drv_q head, pops on handshake
    logic [8:0] drv_q[$];
    int hs_cnt = 0;
    int drop_at = -1;

    initial begin : driver
        logic hs;
        forever begin
            @(negedge clk);
            hs = s_valid && s_ready;
            @(posedge clk);
            #1;
            if (hs && drv_q.size() > 0) begin
                void'(drv_q.pop_front());
                hs_cnt++;
            end
            if (drv_q.size() > 0 && hs_cnt != drop_at) begin
                s_valid = 1'b1;
                s_last  = drv_q[0][8];
                s_data  = drv_q[0][7:0];
            end else begin
                s_valid = 1'b0;
                s_last  = 1'b0;
                s_data  = 8'd0;
            end
        end
    end

    // ---------------- monitor
    logic [3:0] cap_q[$];
    int txen_cyc = 0, txer_cyc = 0, und_cyc = 0, rdy_consec = 0, rdy_outside = 0;
    logic rdy_prev = 1'b0;

    always @(negedge clk) begin
        if (txen) cap_q.push_back(dataout);
        if (txen) txen_cyc <= txen_cyc + 1;
        if (txer) txer_cyc <= txer_cyc + 1;
        if (underrun) und_cyc <= und_cyc + 1;
        if (s_ready && rdy_prev) rdy_consec <= rdy_consec + 1;
        if (s_ready && !txen) rdy_outside <= rdy_outside + 1;
        rdy_prev <= s_ready;
    end

    // ---------------- reference model: whole-frame nibble stream from byte rules
    logic [7:0]  body_q[$];
    logic [3:0]  exp_q[$];
    logic [15:0] exp_fc = 16'd0;

    function automatic void model_frame(input int n_sent, input bit aborted);
        logic [7:0]  fr[$];
        logic [31:0] c;
        exp_q.delete();
        repeat (15) exp_q.push_back(4'h5);
        exp_q.push_back(4'hD);
        for (int i = 0; i < n_sent; i++) fr.push_back(body_q[i]);
        if (!aborted) while (fr.size() < 60) fr.push_back(8'h00);
        foreach (fr[i]) begin
            exp_q.push_back(fr[i][3:0]);
            exp_q.push_back(fr[i][7:4]);
        end
        if (aborted) begin
            exp_q.push_back(4'h0);
            return;
        end
        c = 32'hFFFFFFFF;
        foreach (fr[i]) begin
            c = c ^ {24'd0, fr[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        c = ~c;
        for (int k = 0; k < 8; k++) exp_q.push_back(c[4*k +: 4]);
    endfunction

    task automatic fill_body(input int len, input int kind);
        body_q.delete();
        for (int i = 0; i < len; i++) begin
            case (kind)
                0:       body_q.push_back(8'hAB);
                1:       body_q.push_back((i < 9) ? 8'(8'h31 + i) : 8'h00);
                2:       body_q.push_back(8'(i));
                default: body_q.push_back(8'($urandom_range(0, 255)));
            endcase
        end
    endtask

    task automatic push_body();
        for (int i = 0; i < body_q.size(); i++)
            drv_q.push_back({(i == body_q.size() - 1), body_q[i]});
    endtask

    // Waits for a frame to start and end, then counts busy idle cycles (IFG).
    task automatic wait_frame(input string name, output int ifg);
        int n;
        int to;
        to = 0;
        n = 0;
        while (!txen && n < 400) begin @(negedge clk); n++; end
        if (n >= 400) to++;
        n = 0;
        while (txen && n < 5000) begin @(negedge clk); n++; end
        if (n >= 5000) to++;
        ifg = 0;
        while (busy && !txen && ifg < 40) begin ifg++; @(negedge clk); end
        check({name, " timeout"}, to, 0);
    endtask

    task automatic run_case(input string name, input int drop_rel, input int exp_txen,
                            input int exp_hs, input int exp_und);
        int base, hs0, txen0, txer0, und0, ifg, nmis;
        base  = cap_q.size();
        hs0   = hs_cnt;
        txen0 = txen_cyc;
        txer0 = txer_cyc;
        und0  = und_cyc;
        model_frame((drop_rel < 0) ? body_q.size() : drop_rel, drop_rel >= 0);
        drop_at = (drop_rel < 0) ? -1 : hs_cnt + drop_rel;
        push_body();
        wait_frame(name, ifg);
        if (drop_rel < 0) exp_fc = exp_fc + 16'd1;
        check({name, " txen_cycles"}, txen_cyc - txen0, exp_txen);
        check({name, " handshakes"}, hs_cnt - hs0, exp_hs);
        check({name, " underrun"}, und_cyc - und0, exp_und);
        check({name, " txer_cycles"}, txer_cyc - txer0, exp_und);
        check({name, " ifg"}, ifg, 24);
        check({name, " frame_cnt"}, frame_cnt, exp_fc);
        nmis = 0;
        foreach (exp_q[i]) begin
            if (base + i >= cap_q.size()) nmis++;
            else if (cap_q[base + i] !== exp_q[i]) nmis++;
        end
        check({name, " nibble_errors"}, nmis, 0);
        if (drop_rel >= 0) begin
            drv_q.delete();
            drop_at = -1;
        end
    endtask

    typedef struct {
        int len;
        int kind;
        int drop;
        int exp_txen;
        int exp_hs;
        int exp_und;
    } vec_t;

    vec_t vecs[6];

    initial begin : main
        int ifg, gap, hs0, n, t0, len, drop;
        vecs[0] = '{1,   0, -1, 144, 1,   0};
        vecs[1] = '{60,  1, -1, 144, 60,  0};
        vecs[2] = '{100, 2, -1, 224, 100, 0};
        vecs[3] = '{64,  2, 10, 37,  10,  1};
        vecs[4] = '{59,  3, -1, 144, 59,  0};
        vecs[5] = '{61,  3, -1, 146, 61,  0};

        repeat (3) @(negedge clk);
        check("reset txen", txen, 0);
        check("reset txer", txer, 0);
        check("reset dataout", dataout, 0);
        check("reset s_ready", s_ready, 0);
        check("reset busy", busy, 0);
        check("reset underrun", underrun, 0);
        check("reset frame_cnt", frame_cnt, 0);
        check("reset state", state_dbg, 32'(S_IDLE));
        reset = 1'b0;

        // Standalone CRC unit over "123456789".
        @(posedge clk); #1;
        cu_init = 1'b1;
        @(posedge clk); #1;
        cu_init = 1'b0;
        cu_en   = 1'b1;
        for (int i = 0; i < 9; i++) begin
            logic [7:0] b;
            b = 8'(8'h31 + i);
            cu_nib = b[3:0];
            @(posedge clk); #1;
            cu_nib = b[7:4];
            @(posedge clk); #1;
        end
        cu_en = 1'b0;
        check("crc_unit check value", ~cu_crc, 32'hCBF43926);
        @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            fill_body(vecs[v].len, vecs[v].kind);
            run_case($sformatf("vec%0d", v), vecs[v].drop, vecs[v].exp_txen,
                     vecs[v].exp_hs, vecs[v].exp_und);
        end

        for (int r = 0; r < 8; r++) begin
            len = $urandom_range(1, 130);
            fill_body(len, 3);
            drop = ($urandom_range(0, 3) == 0 && len >= 2) ? $urandom_range(1, len - 1) : -1;
            run_case($sformatf("rand%0d", r), drop,
                     (drop < 0) ? 16 + 2 * ((len < 60) ? 60 : len) + 8 : 16 + 2 * drop + 1,
                     (drop < 0) ? len : drop, (drop < 0) ? 0 : 1);
        end

        // Back-to-back frames with s_valid held high.
        hs0 = hs_cnt;
        fill_body(70, 2);
        push_body();
        fill_body(20, 3);
        push_body();
        wait_frame("b2b first", ifg);
        check("b2b first ifg", ifg, 24);
        gap = ifg;
        while (!txen && gap < 60) begin gap++; @(negedge clk); end
        check("b2b gap", gap, 25);
        wait_frame("b2b second", ifg);
        check("b2b second ifg", ifg, 24);
        exp_fc = exp_fc + 16'd2;
        check("b2b frame_cnt", frame_cnt, exp_fc);
        check("b2b handshakes", hs_cnt - hs0, 90);

        // Reset while in DATA.
        fill_body(80, 3);
        push_body();
        t0 = txen_cyc;
        n = 0;
        while (txen_cyc - t0 < 40 && n < 400) begin @(negedge clk); n++; end
        @(posedge clk); #5;
        reset = 1'b1;
        #1;
        check("midreset txen", txen, 0);
        check("midreset txer", txer, 0);
        check("midreset dataout", dataout, 0);
        check("midreset busy", busy, 0);
        check("midreset s_ready", s_ready, 0);
        @(negedge clk);
        drv_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        exp_fc = 16'd0;
        check("midreset frame_cnt", frame_cnt, exp_fc);
        fill_body(30, 3);
        run_case("post_reset", -1, 144, 30, 0);

        check("s_ready double-wide pulses", rdy_consec, 0);
        check("s_ready outside frame", rdy_outside, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

endmodule
